// File: rtl/led_sequencer.sv
// LED pattern engine: bounce, rotate, table playback and blink modes with a
// programmable step prescaler, run/hold control and a writable pattern table.
module led_sequencer #(
  parameter int N_LEDS  = 8,
  parameter int DEPTH   = 16,
  parameter int PRESC_W = 24,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [1:0]         mode,
  input  logic [PRESC_W-1:0] period,
  input  logic [AW-1:0]      tbl_last,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [N_LEDS-1:0]  wr_data,
  output logic [N_LEDS-1:0]  leds,
  output logic               step,
  output logic               seq_wrap
);

  localparam int PW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam logic [PW-1:0] POS_LAST = PW'(N_LEDS - 1);

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_TABLE  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  mode_e              mode_q, mode_d;
  dir_e               dir_q, dir_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic               phase_q, phase_d;
  logic [N_LEDS-1:0]  leds_q, leds_d;
  logic               step_q, step_d;
  logic               wrap_q, wrap_d;
  logic [N_LEDS-1:0]  tbl_q [DEPTH];

  // NOTE: every variable gets a default first so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    mode_d  = mode_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;

    if (mode_e'(mode) != mode_q) begin
      // A mode change restarts the new sequence cleanly and swallows any tick.
      mode_d  = mode_e'(mode);
      dir_d   = DIR_UP;
      cnt_d   = '0;
      pos_d   = '0;
      idx_d   = '0;
      phase_d = 1'b0;
    end else if (run) begin
      if (cnt_q >= period) begin
        cnt_d  = '0;
        step_d = 1'b1;
        unique case (mode_q)
          MODE_BOUNCE: begin
            if (N_LEDS == 1) begin
              pos_d = '0;
            end else begin
              pos_d = (dir_q == DIR_UP) ? pos_q + 1'b1 : pos_q - 1'b1;
              if (pos_d == POS_LAST)  dir_d = DIR_DOWN;
              else if (pos_d == '0)   dir_d = DIR_UP;
            end
            wrap_d = (pos_d == '0);
          end
          MODE_ROTATE: begin
            pos_d  = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
            wrap_d = (pos_d == '0);
          end
          MODE_TABLE: begin
            // >= so a tbl_last lowered below idx still wraps on the next tick.
            idx_d  = (idx_q >= tbl_last) ? '0 : idx_q + 1'b1;
            wrap_d = (idx_d == '0);
          end
          MODE_BLINK: begin
            phase_d = ~phase_q;
            wrap_d  = phase_q;
          end
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    leds_d = '0;
    unique case (mode_q)
      MODE_BOUNCE,
      MODE_ROTATE: leds_d = N_LEDS'(1) << pos_q;
      MODE_TABLE:  leds_d = tbl_q[idx_q];
      MODE_BLINK:  leds_d = {N_LEDS{phase_q}};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= MODE_BOUNCE;
      dir_q   <= DIR_UP;
      cnt_q   <= '0;
      pos_q   <= '0;
      idx_q   <= '0;
      phase_q <= 1'b0;
      leds_q  <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      leds_q  <= leds_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  // NOTE: the pattern table is reset to a known one-hot walk, so it is built
  // from flops with a reset rather than an uninitialised RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= N_LEDS'(1) << (i % N_LEDS);
      end
    end else if (wr_en) begin
      tbl_q[wr_addr] <= wr_data;
    end
  end

  assign leds     = leds_q;
  assign step     = step_q;
  assign seq_wrap = wrap_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: rotate, bounce, table playback and writes,
// run/hold, mode switching and asynchronous reset.
module tb_led_sequencer;

  localparam int N  = 8;
  localparam int D  = 16;
  localparam int PW = 24;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [1:0]    mode;
  logic [PW-1:0] period;
  logic [AW-1:0] tbl_last;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_data;
  logic [N-1:0]  leds;
  logic          step;
  logic          seq_wrap;

  int tests_run    = 0;
  int tests_failed = 0;

  led_sequencer #(.N_LEDS(N), .DEPTH(D), .PRESC_W(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .mode     (mode),
    .period   (period),
    .tbl_last (tbl_last),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .leds     (leds),
    .step     (step),
    .seq_wrap (seq_wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_step(input int bound, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < bound && !ok) begin
      tick();
      n++;
      if (step === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; run = 1'b1; mode = 2'd1; period = PW'(3);
    tbl_last = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #1;
    tests_run++;
    if ({leds, step, seq_wrap} !== 10'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got leds=%h step=%b wrap=%b expected 00/0/0", leds, step, seq_wrap);
    end
    repeat (3) tick();
    tests_run++;
    if ({leds, step, seq_wrap} !== 10'b0) begin
      tests_failed++;
      $display("FAIL reset_held: got leds=%h step=%b wrap=%b expected 00/0/0", leds, step, seq_wrap);
    end
    rst = 1'b1;
  endtask

  task automatic test_rotate();
    int n;
    bit ok;
    logic [N-1:0] exp;
    for (int k = 1; k <= 8; k++) begin
      wait_step(12, n, ok);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL rotate_step_timeout k=%0d: got no step in %0d cycles expected one", k, n);
        return;
      end
      tests_run++;
      if (n !== ((k == 1) ? 5 : 3)) begin
        tests_failed++;
        $display("FAIL rotate_interval k=%0d: got %0d expected %0d", k, n, (k == 1) ? 5 : 3);
      end
      tests_run++;
      if (seq_wrap !== (k == 8)) begin
        tests_failed++;
        $display("FAIL rotate_wrap k=%0d: got %b expected %b", k, seq_wrap, k == 8);
      end
      tick();
      exp = 8'h01 << (k % 8);
      tests_run++;
      if (leds !== exp) begin
        tests_failed++;
        $display("FAIL rotate_leds k=%0d: got %h expected %h", k, leds, exp);
      end
    end
  endtask

  task automatic test_bounce();
    int p;
    logic [N-1:0] exp;
    mode = 2'd0; period = '0;
    tick();
    tests_run++;
    if (step !== 1'b0) begin
      tests_failed++;
      $display("FAIL bounce_switch_step: got %b expected 0", step);
    end
    for (int k = 1; k <= 28; k++) begin
      tick();
      p   = (k - 1) % 14;
      p   = (p < 8) ? p : 14 - p;
      exp = 8'h01 << p;
      tests_run++;
      if (step !== 1'b1 || seq_wrap !== (k % 14 == 0)) begin
        tests_failed++;
        $display("FAIL bounce_step k=%0d: got step=%b wrap=%b expected 1/%b", k, step, seq_wrap, k % 14 == 0);
      end
      tests_run++;
      if (leds !== exp) begin
        tests_failed++;
        $display("FAIL bounce_leds k=%0d: got %h expected %h", k, leds, exp);
      end
    end
  endtask

  task automatic test_table();
    logic [N-1:0] exp_tab [4];
    exp_tab[0] = 8'hAA; exp_tab[1] = 8'h55; exp_tab[2] = 8'hFF; exp_tab[3] = 8'hAA;
    wr_en = 1'b1;
    wr_addr = 4'd0; wr_data = 8'hAA; tick();
    wr_addr = 4'd1; wr_data = 8'h55; tick();
    wr_addr = 4'd2; wr_data = 8'hFF; tick();
    wr_en = 1'b0; tbl_last = 4'd2; mode = 2'd2;
    tick();
    tests_run++;
    if (step !== 1'b0) begin
      tests_failed++;
      $display("FAIL table_switch_step: got %b expected 0", step);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests_run++;
      if (leds !== exp_tab[k-1] || seq_wrap !== (k == 3)) begin
        tests_failed++;
        $display("FAIL table_play k=%0d: got leds=%h wrap=%b expected %h/%b", k, leds, seq_wrap, exp_tab[k-1], k == 3);
      end
    end
    run = 1'b0;
    tick();
    tests_run++;
    if (leds !== 8'h55 || step !== 1'b0) begin
      tests_failed++;
      $display("FAIL table_hold: got leds=%h step=%b expected 55/0", leds, step);
    end
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'h0F;
    tick();
    wr_en = 1'b0;
    tests_run++;
    if (leds !== 8'h55) begin
      tests_failed++;
      $display("FAIL table_write_old: got %h expected 55", leds);
    end
    tick();
    tests_run++;
    if (leds !== 8'h0F) begin
      tests_failed++;
      $display("FAIL table_write_new: got %h expected 0f", leds);
    end
  endtask

  task automatic test_hold();
    int n;
    bit ok;
    bit stepped;
    bit changed;
    logic [N-1:0] held;
    mode = 2'd1; period = PW'(9); run = 1'b1;
    wait_step(40, n, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL hold_first_step: got no step in %0d cycles expected one", n);
      return;
    end
    repeat (3) tick();
    run = 1'b0;
    held = leds; stepped = 1'b0; changed = 1'b0;
    repeat (50) begin
      tick();
      if (step !== 1'b0) stepped = 1'b1;
      if (leds !== held) changed = 1'b1;
    end
    tests_run++;
    if (stepped || changed) begin
      tests_failed++;
      $display("FAIL hold_frozen: got stepped=%b changed=%b expected 0/0", stepped, changed);
    end
    run = 1'b1;
    wait_step(40, n, ok);
    tests_run++;
    if (!ok || n !== 7) begin
      tests_failed++;
      $display("FAIL hold_resume: got ok=%b cycles=%0d expected 1/7", ok, n);
    end
  endtask

  task automatic test_mode_switch();
    bit found = 1'b0;
    logic [N-1:0] exp;
    period = '0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (leds === 8'h10) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL switch_find_10: got leds=%h expected 10 within 20 cycles", leds);
      return;
    end
    mode = 2'd3;
    tick();
    tests_run++;
    if (step !== 1'b0 || seq_wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL switch_quiet: got step=%b wrap=%b expected 0/0", step, seq_wrap);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp = (k % 2 == 0) ? 8'hFF : 8'h00;
      tests_run++;
      if (step !== 1'b1 || seq_wrap !== (k % 2 == 0) || leds !== exp) begin
        tests_failed++;
        $display("FAIL blink k=%0d: got step=%b wrap=%b leds=%h expected 1/%b/%h", k, step, seq_wrap, leds, k % 2 == 0, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [N-1:0] exp;
    mode = 2'd1;
    repeat (4) tick();
    tests_run++;
    if (step !== 1'b1 || leds === 8'h00) begin
      tests_failed++;
      $display("FAIL areset_precond: got step=%b leds=%h expected 1/nonzero", step, leds);
    end
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({leds, step, seq_wrap} !== 10'b0) begin
      tests_failed++;
      $display("FAIL areset_immediate: got leds=%h step=%b wrap=%b expected 00/0/0", leds, step, seq_wrap);
    end
    repeat (2) tick();
    mode = 2'd2; tbl_last = 4'd3; rst = 1'b1;
    tick();
    tests_run++;
    if (step !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_switch_step: got %b expected 0", step);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp = 8'h01 << ((k - 1) % 4);
      tests_run++;
      if (leds !== exp || seq_wrap !== (k == 4)) begin
        tests_failed++;
        $display("FAIL areset_default_table k=%0d: got leds=%h wrap=%b expected %h/%b", k, leds, seq_wrap, exp, k == 4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_bounce();
    test_table();
    test_hold();
    test_mode_switch();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
